// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Sequencing controller for a 5-stage RV32 pipeline.
// - A small scoreboard records the destination registers of instructions
//   that are ahead of ID and have not yet written back.
// - Read-after-write hazards are detected at ID. On a hazard the PC and
//   IF/ID are held and a bubble goes into ID/EX.
// - A taken branch or jump resolved in EX squashes the wrong path for
//   1 + FLUSH_CYCLES cycles.
//
// Ports:
//   CLK           clock, rising edge
//   rst           synchronous, active-low reset
//   id_valid      IF/ID holds a real instruction
//   id_rs1/rs2    source indices of the ID instruction
//   id_use_rs1/2  the ID instruction actually reads that source
//   id_rd         destination index of the ID instruction
//   id_reg_write  the ID instruction writes id_rd
//   ex_redirect   taken branch/jump resolved in EX this cycle
//   stall_if      hold PC and IF/ID
//   flush_ifid    clear IF/ID at the next edge
//   bubble_idex   load NOP control into ID/EX at the next edge
//   issue         ID instruction advances into ID/EX at the next edge
//   state         0 = RUN, 1 = STALL, 2 = FLUSH
//   stall_count   saturating count of hazard-stall cycles
//   flush_count   saturating count of flush cycles (redirect cycles included)
module pipeline_hazard_ctrl #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DEPTH        = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [ADDR_WIDTH-1:0] id_rs1,
  input  logic [ADDR_WIDTH-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [ADDR_WIDTH-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  ex_redirect,
  output logic                  stall_if,
  output logic                  flush_ifid,
  output logic                  bubble_idex,
  output logic                  issue,
  output logic [1:0]            state,
  output logic [15:0]           stall_count,
  output logic [15:0]           flush_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [3:0]            FLUSH_LOAD = 4'(FLUSH_CYCLES);
  localparam logic [15:0]           CNT_MAX    = 16'hFFFF;
  localparam logic [ADDR_WIDTH-1:0] REG_X0     = {ADDR_WIDTH{1'b0}};

  state_t                state_r;
  state_t                state_nxt_s;
  logic [3:0]            fcnt_r;
  logic [3:0]            fcnt_nxt_s;
  logic [DEPTH-1:0]      slot_valid_r;
  logic [ADDR_WIDTH-1:0] slot_rd_r [DEPTH];
  logic [15:0]           stall_count_r;
  logic [15:0]           flush_count_r;

  logic match_rs1_s;
  logic match_rs2_s;
  logic hazard_s;
  logic stall_if_s;
  logic flush_ifid_s;
  logic bubble_idex_s;
  logic issue_s;

  // Scoreboard lookup: does any in-flight valid slot target rs1 / rs2.
  always_comb begin
    match_rs1_s = 1'b0;
    match_rs2_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      match_rs1_s = match_rs1_s | (slot_valid_r[i] & (slot_rd_r[i] == id_rs1));
      match_rs2_s = match_rs2_s | (slot_valid_r[i] & (slot_rd_r[i] == id_rs2));
    end
  end

  // x0 is hard-wired to zero, so reading it can never depend on a producer.
  assign hazard_s = id_valid &
                    ((id_use_rs1 & (id_rs1 != REG_X0) & match_rs1_s) |
                     (id_use_rs2 & (id_rs2 != REG_X0) & match_rs2_s));

  // Next-state and control outputs; redirect beats hazard beats issue.
  always_comb begin
    state_nxt_s   = state_r;
    fcnt_nxt_s    = fcnt_r;
    stall_if_s    = 1'b0;
    flush_ifid_s  = 1'b0;
    bubble_idex_s = 1'b0;
    issue_s       = 1'b0;
    if (!rst) begin
      // Outputs stay quiet during reset so no register sees a stray squash.
      state_nxt_s = ST_RUN;
      fcnt_nxt_s  = 4'd0;
    end else if (ex_redirect) begin
      flush_ifid_s  = 1'b1;
      bubble_idex_s = 1'b1;
      if (FLUSH_LOAD == 4'd0) begin
        state_nxt_s = ST_RUN;
        fcnt_nxt_s  = 4'd0;
      end else begin
        state_nxt_s = ST_FLUSH;
        fcnt_nxt_s  = FLUSH_LOAD;
      end
    end else begin
      case (state_r)
        ST_RUN, ST_STALL: begin
          if (hazard_s) begin
            stall_if_s    = 1'b1;
            bubble_idex_s = 1'b1;
            state_nxt_s   = ST_STALL;
          end else begin
            issue_s     = id_valid;
            state_nxt_s = ST_RUN;
          end
        end
        ST_FLUSH: begin
          // Wrong-path squash; hazards are irrelevant for squashed slots.
          flush_ifid_s  = 1'b1;
          bubble_idex_s = 1'b1;
          if (fcnt_r <= 4'd1) begin
            state_nxt_s = ST_RUN;
            fcnt_nxt_s  = 4'd0;
          end else begin
            fcnt_nxt_s = fcnt_r - 4'd1;
          end
        end
        default: begin
          state_nxt_s = ST_RUN;
          fcnt_nxt_s  = 4'd0;
        end
      endcase
    end
  end

  // FSM state and flush down-counter.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      state_r <= ST_RUN;
      fcnt_r  <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      fcnt_r  <= fcnt_nxt_s;
    end
  end

  // Scoreboard shift: slot 0 is EX; the last slot retires with the RF write.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      slot_valid_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        slot_rd_r[i] <= REG_X0;
      end
    end else begin
      // Bubbles, squashes and x0 writes enter as invalid slots.
      slot_valid_r[0] <= issue_s & id_reg_write & (id_rd != REG_X0);
      slot_rd_r[0]    <= id_rd;
      for (int i = 1; i < DEPTH; i++) begin
        slot_valid_r[i] <= slot_valid_r[i-1];
        slot_rd_r[i]    <= slot_rd_r[i-1];
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      stall_count_r <= 16'd0;
      flush_count_r <= 16'd0;
    end else begin
      if (stall_if_s && (stall_count_r != CNT_MAX)) begin
        stall_count_r <= stall_count_r + 16'd1;
      end else begin
        stall_count_r <= stall_count_r;
      end
      if (flush_ifid_s && (flush_count_r != CNT_MAX)) begin
        flush_count_r <= flush_count_r + 16'd1;
      end else begin
        flush_count_r <= flush_count_r;
      end
    end
  end

  assign stall_if    = stall_if_s;
  assign flush_ifid  = flush_ifid_s;
  assign bubble_idex = bubble_idex_s;
  assign issue       = issue_s;
  assign state       = state_r;
  assign stall_count = stall_count_r;
  assign flush_count = flush_count_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl.
// Main instance uses default parameters (DEPTH=2, FLUSH_CYCLES=1).
// A second instance with DEPTH=15 drives stall_count into saturation quickly
// because a self-dependent instruction then stalls 15 of every 16 cycles.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // main instance signals
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_reg_write;
  logic        ex_redirect;
  logic        stall_if, flush_ifid, bubble_idex, issue;
  logic [1:0]  state;
  logic [15:0] stall_count, flush_count;
  logic [3:0]  outs;
  assign outs = {stall_if, flush_ifid, bubble_idex, issue};

  // saturation instance signals
  logic        s_rst;
  logic        s_stall_if, s_flush_ifid, s_bubble_idex, s_issue;
  logic [1:0]  s_state;
  logic [15:0] s_stall_count, s_flush_count;

  pipeline_hazard_ctrl dut (
    .CLK(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .ex_redirect(ex_redirect),
    .stall_if(stall_if), .flush_ifid(flush_ifid), .bubble_idex(bubble_idex),
    .issue(issue), .state(state), .stall_count(stall_count),
    .flush_count(flush_count)
  );

  pipeline_hazard_ctrl #(.ADDR_WIDTH(5), .DEPTH(15), .FLUSH_CYCLES(1)) dut_sat (
    .CLK(clk), .rst(s_rst), .id_valid(1'b1),
    .id_rs1(5'd5), .id_rs2(5'd0),
    .id_use_rs1(1'b1), .id_use_rs2(1'b0),
    .id_rd(5'd5), .id_reg_write(1'b1), .ex_redirect(1'b0),
    .stall_if(s_stall_if), .flush_ifid(s_flush_ifid), .bubble_idex(s_bubble_idex),
    .issue(s_issue), .state(s_state), .stall_count(s_stall_count),
    .flush_count(s_flush_count)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2,
                        input logic [4:0] rd, input logic w);
    id_valid     = v;
    id_rs1       = r1;
    id_use_rs1   = u1;
    id_rs2       = r2;
    id_use_rs2   = u2;
    id_rd        = rd;
    id_reg_write = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic hit;
  int   n;

  initial begin
    rst         = 1'b0;
    s_rst       = 1'b0;
    ex_redirect = 1'b0;
    // valid instruction present during reset
    set_id(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1);

    // ---- reset: 3 cycles low, outputs forced to 0 ----
    @(negedge clk); check("rst_outs_c0", 16'(outs), 16'b0000);
    tick();
    ex_redirect = 1'b1;
    @(negedge clk); check("rst_outs_redirect", 16'(outs), 16'b0000);
    tick();
    ex_redirect = 1'b0;
    @(negedge clk); check("rst_outs_c2", 16'(outs), 16'b0000);
    tick();
    rst = 1'b1;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    check("rst_state", 16'(state), 16'd0);
    check("rst_stall_count", stall_count, 16'd0);
    check("rst_flush_count", flush_count, 16'd0);
    tick();

    // ---- back-to-back RAW: add x5 ; sub x6,x5,x1 ----
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1);
    @(negedge clk); check("raw_producer_issue", 16'(outs), 16'b0001);
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1);
    @(negedge clk);
    check("raw_stall1_outs", 16'(outs), 16'b1010);
    check("raw_stall1_state", 16'(state), 16'd0);
    tick();
    @(negedge clk);
    check("raw_stall2_outs", 16'(outs), 16'b1010);
    check("raw_stall2_state", 16'(state), 16'd1);
    tick();
    @(negedge clk);
    check("raw_release_outs", 16'(outs), 16'b0001);
    check("raw_release_state", 16'(state), 16'd1);
    check("raw_stall_count", stall_count, 16'd2);
    tick();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    check("raw_back_to_run", 16'(state), 16'd0);
    check("raw_idle_outs", 16'(outs), 16'b0000);
    tick();

    // ---- x0 destination: addi x0 ; add x7,x0,x0 ----
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1);
    @(negedge clk); check("x0_writer_issue", 16'(outs), 16'b0001);
    tick();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1);
    @(negedge clk);
    check("x0_reader_issue", 16'(outs), 16'b0001);
    check("x0_no_stall_count", stall_count, 16'd2);
    tick();

    // ---- taken branch; wrong-path writer of x9 ----
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1);
    ex_redirect = 1'b1;
    @(negedge clk); check("br_redirect_outs", 16'(outs), 16'b0110);
    tick();
    ex_redirect = 1'b0;
    @(negedge clk);
    check("br_flush_state", 16'(state), 16'd2);
    check("br_flush_outs", 16'(outs), 16'b0110);
    tick();
    set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1);
    @(negedge clk);
    check("br_run_state", 16'(state), 16'd0);
    check("br_flush_count", flush_count, 16'd2);
    check("br_x9_reader_issue", 16'(outs), 16'b0001);
    tick();

    // ---- simultaneous hazard + redirect ----
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1);
    @(negedge clk); check("sim_producer_issue", 16'(outs), 16'b0001);
    tick();
    set_id(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1);
    ex_redirect = 1'b1;
    @(negedge clk); check("sim_flush_wins", 16'(outs), 16'b0110);
    tick();
    ex_redirect = 1'b0;
    @(negedge clk);
    check("sim_flush_state", 16'(state), 16'd2);
    check("sim_flush_ignores_hazard", 16'(outs), 16'b0110);
    check("sim_stall_count_held", stall_count, 16'd2);
    tick();
    @(negedge clk);
    check("sim_after_issue", 16'(outs), 16'b0001);
    check("sim_flush_count", flush_count, 16'd4);
    check("sim_stall_count_final", stall_count, 16'd2);
    tick();

    // ---- reset in mid-STALL ----
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1);
    @(negedge clk); check("mr_producer_issue", 16'(outs), 16'b0001);
    tick();
    set_id(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1);
    @(negedge clk); check("mr_stall_outs", 16'(outs), 16'b1010);
    tick();
    @(negedge clk); check("mr_in_stall", 16'(state), 16'd1);
    rst = 1'b0;
    #1;
    check("mr_rst_outs", 16'(outs), 16'b0000);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("mr_state", 16'(state), 16'd0);
    check("mr_stall_count", stall_count, 16'd0);
    check("mr_sb_empty_issue", 16'(outs), 16'b0001);
    tick();

    // ---- saturation on the DEPTH=15 instance ----
    s_rst = 1'b1;
    hit   = 1'b0;
    for (int c = 0; c < 80000; c++) begin
      @(negedge clk);
      if (s_stall_count == 16'hFFFE) begin
        hit = 1'b1;
        break;
      end
    end
    check("sat_reach_fffe", 16'(hit), 16'd1);
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      if (s_stall_if) n++;
      @(negedge clk);
    end
    check("sat_three_stalls", 16'(n), 16'd3);
    check("sat_hold_ffff", s_stall_count, 16'hFFFF);
    check("sat_flush_count", s_flush_count, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Sequencing controller for the 5-stage RV32 pipeline. It tracks in-flight destination registers in a small scoreboard and detects read-after-write hazards at the ID stage. On a hazard it stalls the PC and the IF/ID register and injects a bubble into ID/EX. On a taken branch or jump resolved in EX, it flushes the wrong-path instructions for a configured number of cycles. It sits beside the control decoder and drives the hold, flush and bubble inputs of the PC, IF/ID and ID/EX registers.

## Interface
- ADDR_WIDTH, 5, register-index width
- DEPTH, 2, number of scoreboard slots: instructions ahead of ID that have not yet written back (EX, MEM/WB)
- FLUSH_CYCLES, 1, extra squash cycles after the redirect cycle; legal range 0..15
- CLK  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-low
- id_valid  in  1  IF/ID holds a real instruction
- id_rs1, id_rs2  in  ADDR_WIDTH  source register indices of the ID instruction
- id_use_rs1, id_use_rs2  in  1  the ID instruction actually reads that source
- id_rd  in  ADDR_WIDTH  destination index of the ID instruction
- id_reg_write  in  1  the ID instruction writes id_rd
- ex_redirect  in  1  a taken branch or jump is resolved in EX this cycle
- stall_if  out  1  hold the PC and IF/ID register
- flush_ifid  out  1  clear the IF/ID register at the next edge
- bubble_idex  out  1  load NOP control into ID/EX at the next edge
- issue  out  1  the ID instruction advances into ID/EX at the next edge
- state  out  2  FSM state: 0 = RUN, 1 = STALL, 2 = FLUSH
- stall_count  out  16  cumulative hazard-stall cycles, saturating
- flush_count  out  16  cumulative flush cycles, including redirect cycles, saturating

## Operation
- **Scoreboard:** DEPTH slots, each holding {valid, rd}. Slot 0 is the instruction now in EX. Every edge:
  - slots shift, slot i to slot i+1, and the last slot retires;
  - slot 0 loads {1, id_rd} when issue=1, id_reg_write=1 and id_rd!=0;
  - otherwise slot 0 loads invalid. This covers bubbles and squashed instructions.
- **Hazard:** `hazard = id_valid & ((id_use_rs1 & rs1!=0 & match(rs1)) | (id_use_rs2 & rs2!=0 & match(rs2)))`, where match(r) is true if any valid slot has rd == r. Register x0 never causes a hazard.
- **FSM output priority:** redirect, then hazard, then normal issue. Outputs are combinational from state and inputs.
  - **ex_redirect=1 (any state):**
    - outputs: flush_ifid=1, bubble_idex=1, issue=0, stall_if=0;
    - next state is FLUSH with counter=FLUSH_CYCLES, or RUN if FLUSH_CYCLES=0.
  - **RUN or STALL, hazard=1:**
    - outputs: stall_if=1, bubble_idex=1, issue=0;
    - next state is STALL.
  - **RUN or STALL, no hazard:**
    - outputs: issue=id_valid, all other outputs 0;
    - next state is RUN.
  - **FLUSH:**
    - outputs: flush_ifid=1, bubble_idex=1, issue=0;
    - counter decrements each cycle; the state leaves for RUN on the edge where counter==1;
    - hazard is ignored while in FLUSH.
- **Counters:**
  - stall_count increments in each cycle where stall_if=1;
  - flush_count increments in each cycle where flush_ifid=1;
  - both saturate at 16'hFFFF and never wrap.
- **Reset:**
  - while rst=0, outputs are forced to stall_if=0, flush_ifid=0, bubble_idex=0, issue=0;
  - at the edge: all slots become invalid, state=RUN (0), FLUSH counter=0, stall_count=0, flush_count=0;
  - reset in mid-STALL or mid-FLUSH aborts that state with no residual squash.

## Timing
- Hazard to stall: 0 cycles; same-cycle combinational.
- Stall length for a dependency on the instruction directly ahead = DEPTH cycles.
- Stall length for a dependency two instructions ahead = DEPTH-1 cycles.
- Squashed slots per redirect = 1 + FLUSH_CYCLES cycles.
- A slot retires at the same edge as the register-file write. The register file is write-first, so a consumer may issue in that retiring cycle.
- stall_if and flush_ifid are never both 1.
- bubble_idex=1 implies issue=0.

## Test plan
- **Reset:** hold rst=0 for 3 cycles with id_valid=1 → all outputs 0; after release, state=0 and both counters 0.
- **Back-to-back RAW:** issue `add x5` then `sub x6,x5,x1` → stall_if=1 for exactly 2 cycles, stall_count=2, then issue=1 with state returning to 0.
- **x0 destination:** `addi x0` followed by `add x7,x0,x0` → no stall, issue=1 on consecutive cycles.
- **Taken branch:** ex_redirect pulse with FLUSH_CYCLES=1 → flush_ifid=1 for 2 cycles, state goes 2 then 0, flush_count=2, the squashed write to x9 is never scoreboarded, and a following reader of x9 does not stall.
- **Simultaneous events:** hazard=1 and ex_redirect=1 in the same cycle → flush wins: stall_if=0, stall_count unchanged.
- **Saturation and mid-stall reset:** preload stall_count to 16'hFFFE and force 3 stall cycles → it holds at 16'hFFFF. Then assert rst=0 in STALL → next cycle state=0 and the scoreboard is empty.
